// File: rtl/bandit_pkg.sv
// Shared types and constants for the epsilon-greedy bandit.
package bandit_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    ACTION = 2'd1,
    REWARD = 2'd2,
    UPDATE = 2'd3
  } state_t;

  typedef logic signed [15:0] value_t;
  typedef logic [7:0]         action_t;

  // Feedback taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bandit_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left and feeds the tap parity into bit 0.
module lfsr16
  import bandit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  // Advance every clock; reload the seed while in reset.
  always_ff @(posedge clock) begin
    if (reset) state <= SEED;
    else       state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/bandit.sv
// Epsilon-greedy multi-armed bandit: linear argmax scan over the action value
// table, action/reward handshakes, then an exponential-average table update.
module bandit
  import bandit_pkg::*;
#(
  parameter int          NUM_ACTIONS = 256,
  parameter int          VALUE_WIDTH = 16,
  parameter logic [7:0]  EPSILON     = 8'd16,
  parameter int          ALPHA_SHIFT = 2,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reward_valid,
  input  logic signed [VALUE_WIDTH-1:0] reward_data,
  output logic                          reward_ready,
  output logic                          action_valid,
  output action_t                       action_data,
  input  logic                          action_ready
);

  // Not reset: learned values survive a reset of the control path.
  logic signed [VALUE_WIDTH-1:0] action_value_table [NUM_ACTIONS];

  state_t                        state, state_nxt;
  action_t                       scan_idx, best_idx, pick_idx;
  logic signed [VALUE_WIDTH-1:0] best_val, scan_val, reward_q, q_cur, q_new;
  logic signed [VALUE_WIDTH:0]   diff, step, sum;
  logic [15:0]                   lfsr;
  logic                          scan_last, take_new, explore;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  // Scan compare: entry 0 seeds the running max, later entries must be
  // strictly greater so ties keep the lowest index.
  assign scan_val  = action_value_table[scan_idx];
  assign scan_last = (scan_idx == action_t'(NUM_ACTIONS - 1));
  assign take_new  = (scan_idx == '0) || (scan_val > best_val);
  assign pick_idx  = take_new ? scan_idx : best_idx;
  assign explore   = (lfsr[7:0] < EPSILON);

  // One-extra-bit difference keeps r - Q exact; the floor shift then brings
  // the step back into range so the sum always fits without saturation.
  assign q_cur = action_value_table[action_data];
  assign diff  = {reward_q[VALUE_WIDTH-1], reward_q} - {q_cur[VALUE_WIDTH-1], q_cur};
  assign step  = diff >>> ALPHA_SHIFT;
  assign sum   = {q_cur[VALUE_WIDTH-1], q_cur} + step;
  assign q_new = sum[VALUE_WIDTH-1:0];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= SELECT;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SELECT: if (scan_last)                     state_nxt = ACTION;
      ACTION: if (action_valid && action_ready)  state_nxt = REWARD;
      REWARD: if (reward_valid && reward_ready)  state_nxt = UPDATE;
      UPDATE:                                    state_nxt = SELECT;
      default:                                   state_nxt = SELECT;
    endcase
  end

  // Handshake outputs; held low during reset so nothing completes mid-reset.
  always_comb begin
    action_valid = 1'b0;
    reward_ready = 1'b0;
    if (!reset) begin
      action_valid = (state == ACTION);
      reward_ready = (state == REWARD);
    end
  end

  // Scan bookkeeping, action choice at end of scan, reward capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_idx    <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      action_data <= '0;
      reward_q    <= '0;
    end else begin
      if (state == SELECT) begin
        best_idx <= pick_idx;
        if (take_new) best_val <= scan_val;
        if (scan_last) begin
          scan_idx    <= '0;
          action_data <= explore ? lfsr[15:8] : pick_idx;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
      if (reward_valid && reward_ready) reward_q <= reward_data;
    end
  end

  // Single table write per loop, only for the issued arm.
  always_ff @(posedge clock) begin
    if (!reset && state == UPDATE) action_value_table[action_data] <= q_new;
  end

endmodule

// File: tb/tb_bandit.sv
// Bench for bandit: greedy instance (EPSILON=0) for latency, learning and
// handshake behaviour; always-explore instance (EPSILON=255) for LFSR choice.
module tb_bandit;

  localparam int N     = 256;
  localparam int ADIV  = 4;          // 2**ALPHA_SHIFT
  localparam logic [15:0] SEED = 16'hACE1;

  logic               clock = 1'b0;
  logic               rst [2];
  logic               rv  [2];
  logic               ar  [2];
  logic signed [15:0] rd  [2];
  logic               rr  [2];
  logic               av  [2];
  logic [7:0]         ad  [2];

  int nvec = 0;
  int nerr = 0;
  int q0 [N];
  int q1 [N];
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_prev = SEED;

  always #5 clock = ~clock;

  bandit #(.EPSILON(8'd0), .SEED(SEED)) dut0 (
    .clock(clock), .reset(rst[0]), .reward_valid(rv[0]), .reward_data(rd[0]),
    .reward_ready(rr[0]), .action_valid(av[0]), .action_data(ad[0]),
    .action_ready(ar[0]));

  bandit #(.EPSILON(8'd255), .SEED(SEED)) dut1 (
    .clock(clock), .reset(rst[1]), .reward_valid(rv[1]), .reward_data(rd[1]),
    .reward_ready(rr[1]), .action_valid(av[1]), .action_data(ad[1]),
    .action_ready(ar[1]));

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // LFSR reference for dut1; m_prev is the value held during the previous cycle.
  always @(posedge clock) begin
    m_prev = m_lfsr;
    m_lfsr = rst[1] ? SEED : lstep(m_lfsr);
  end

  function automatic int upd(input int q, input int r);
    int d, st;
    d = r - q;
    if (d >= 0) st = d / ADIV;
    else        st = -((-d + ADIV - 1) / ADIV);
    return q + st;
  endfunction

  function automatic int argmax(input int qq [N]);
    int b;
    b = 0;
    for (int i = 1; i < N; i++) if (qq[i] > qq[b]) b = i;
    return b;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_table(input int s);
    int bad, got, exp;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      got = (s == 1) ? int'(dut1.action_value_table[i]) : int'(dut0.action_value_table[i]);
      exp = (s == 1) ? q1[i] : q0[i];
      if (got != exp) bad++;
    end
    chk("table_bad_entries", bad, 0);
  endtask

  task automatic wait_act(input int s, output int a);
    int cnt;
    cnt = 0;
    while (!av[s] && cnt < 2000) begin
      @(negedge clock);
      cnt++;
    end
    chk("action_valid_seen", int'(av[s]), 1);
    a = int'(ad[s]);
  endtask

  // Assumes action_ready is high, so the handshake completes on the next edge.
  task automatic give_reward(input int s, input int r);
    @(negedge clock);
    chk("reward_ready_in_reward", int'(rr[s]), 1);
    rv[s] = 1'b1;
    rd[s] = 16'(r);
    @(negedge clock);
    rv[s] = 1'b0;
    @(negedge clock);
  endtask

  task automatic latency(input int s);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!av[s] && cnt < 2000);
    chk("select_latency", cnt, N);
  endtask

  initial begin
    int a, e, r;
    logic signed [15:0] r16;
    rst = '{1'b1, 1'b1};
    rv  = '{1'b0, 1'b0};
    ar  = '{1'b1, 1'b1};
    rd  = '{16'sd0, 16'sd0};
    for (int i = 0; i < N; i++) begin
      dut0.action_value_table[i] = '0;
      dut1.action_value_table[i] = '0;
      q0[i] = 0;
      q1[i] = 0;
    end

    repeat (3) @(negedge clock);
    chk("reset_action_valid", int'(av[0]), 0);
    chk("reset_reward_ready", int'(rr[0]), 0);
    chk("reset_action_data",  int'(ad[0]), 0);

    // First action after reset with an all-zero table.
    rst[0] = 1'b0;
    latency(0);
    chk("first_action", int'(ad[0]), 0);
    give_reward(0, 100);
    q0[0] = upd(q0[0], 100);
    chk("q0_after_100", int'(dut0.action_value_table[0]), 25);

    wait_act(0, a);
    chk("greedy_action", a, 0);
    give_reward(0, -400);
    q0[0] = upd(q0[0], -400);
    chk("q0_after_m400", int'(dut0.action_value_table[0]), -82);

    // Consumer stalls for 5 cycles in ACTION.
    ar[0] = 1'b0;
    wait_act(0, a);
    chk("tie_lowest_index", a, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_valid", int'(av[0]), 1);
      chk("stall_data",  int'(ad[0]), a);
      chk("stall_ready", int'(rr[0]), 0);
    end
    ar[0] = 1'b1;
    give_reward(0, 40);
    q0[a] = upd(q0[a], 40);
    cmp_table(0);

    // Reward presented early, during the scan.
    rv[0] = 1'b1;
    rd[0] = 16'sd300;
    repeat (10) @(negedge clock);
    chk("early_reward_ready", int'(rr[0]), 0);
    wait_act(0, a);
    chk("early_action", a, argmax(q0));
    @(negedge clock);
    chk("early_ready_in_reward", int'(rr[0]), 1);
    @(negedge clock);
    rv[0] = 1'b0;
    @(negedge clock);
    q0[a] = upd(q0[a], 300);
    cmp_table(0);

    // Reset while in REWARD with a reward pending: no write, table kept.
    wait_act(0, a);
    @(negedge clock);
    rst[0] = 1'b1;
    rv[0]  = 1'b1;
    rd[0]  = 16'sd1234;
    repeat (2) @(negedge clock);
    chk("midreset_valid", int'(av[0]), 0);
    chk("midreset_ready", int'(rr[0]), 0);
    chk("midreset_data",  int'(ad[0]), 0);
    rv[0]  = 1'b0;
    rst[0] = 1'b0;
    cmp_table(0);
    latency(0);
    chk("post_reset_action", int'(ad[0]), argmax(q0));
    give_reward(0, -7);
    q0[int'(ad[0])] = upd(q0[int'(ad[0])], -7);
    cmp_table(0);

    // Random rewards against the greedy model.
    for (int it = 0; it < 4; it++) begin
      r16 = 16'($urandom());
      r = int'(r16);
      e = argmax(q0);
      wait_act(0, a);
      chk("rand_greedy_action", a, e);
      give_reward(0, r);
      q0[a] = upd(q0[a], r);
      chk("rand_greedy_q", int'(dut0.action_value_table[a]), q0[a]);
    end

    // Always-explore instance: action follows the LFSR high byte.
    rst[1] = 1'b0;
    for (int it = 0; it < 10; it++) begin
      wait_act(1, a);
      e = (m_prev[7:0] < 8'd255) ? int'(m_prev[15:8]) : argmax(q1);
      chk("explore_action", a, e);
      r16 = 16'($urandom());
      r = int'(r16);
      give_reward(1, r);
      q1[a] = upd(q1[a], r);
      chk("explore_q", int'(dut1.action_value_table[a]), q1[a]);
      cmp_table(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bandit.md
BANDIT -- requirements
Module: bandit

Interface
REQ-001 Parameter NUM_ACTIONS, default 256: number of arms; the action_value_table depth.
REQ-002 Parameter VALUE_WIDTH, default 16: width of reward and action values, signed two's complement.
REQ-003 Parameter EPSILON, default 8'd16: exploration threshold; probability of exploring is EPSILON/256.
REQ-004 Parameter ALPHA_SHIFT, default 2: learning rate 2^-ALPHA_SHIFT.
REQ-005 Parameter SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-006 Port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port reward_valid, input, 1 bit: reward stream valid.
REQ-009 Port reward_data, input, 16 bits: signed reward for the last issued action.
REQ-010 Port reward_ready, output, 1 bit: the block accepts a reward.
REQ-011 Port action_valid, output, 1 bit: action stream valid.
REQ-012 Port action_data, output, 8 bits: selected arm index.
REQ-013 Port action_ready, input, 1 bit: consumer accepts the action.

Function
REQ-014 Internal memory SHALL be named action_value_table: NUM_ACTIONS x VALUE_WIDTH signed entries, hierarchically writable by a bench, and not cleared by reset.
REQ-015 FSM states SHALL be SELECT, ACTION, REWARD and UPDATE; reset enters SELECT.
REQ-016 SELECT SHALL scan entries 0..NUM_ACTIONS-1, one per clock, tracking the maximum with strict greater-than so that ties resolve to the lowest index; after the last entry it SHALL go to ACTION.
REQ-017 Exploration: at the end of the scan, if lfsr[7:0] < EPSILON, action_data SHALL be lfsr[15:8] instead of the argmax.
REQ-018 The LFSR SHALL be a 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11) advancing every clock outside reset.
REQ-019 In ACTION, action_valid SHALL be 1 and action_data SHALL be held stable until a cycle with action_valid and action_ready both high; that cycle SHALL transition to REWARD.
REQ-020 In REWARD, reward_ready SHALL be 1; on a cycle with reward_valid and reward_ready both high, reward_data SHALL be captured and the FSM SHALL go to UPDATE.
REQ-021 UPDATE SHALL take one cycle to write Q[a] <= Q[a] + ((r - Q[a]) >>> ALPHA_SHIFT), then return to SELECT.
REQ-022 The difference SHALL be computed at VALUE_WIDTH+1 bits with an arithmetic (floor) shift; the result always fits in VALUE_WIDTH bits without saturation.
REQ-023 reward_ready SHALL be 0 outside REWARD; rewards presented early are not accepted until REWARD.
REQ-024 action_valid SHALL be 0 outside ACTION; an action_ready held high permanently SHALL complete in one cycle.
REQ-025 Minimum loop latency SHALL be NUM_ACTIONS+3 cycles: scan, 1 action cycle, 1 reward cycle, 1 update cycle.

Reset
REQ-026 While reset is high: state=SELECT, scan index=0, lfsr=SEED, action_valid=0, reward_ready=0, action_data=0.
REQ-027 Reset mid-handshake SHALL abandon the current action/reward with no table write; the table SHALL be retained.

Structure
REQ-028 A shared package bandit_pkg SHALL hold the state enum, the value_t (signed 16-bit) and action_t (8-bit) typedefs, and the LFSR taps constant.
REQ-029 The LFSR SHALL be a sub-module, lfsr16, with ports clock, reset and an output state.

Verification (EPSILON=0, ALPHA_SHIFT=2, table zeroed before reset)
REQ-030 After reset with action_ready=1 -> action_valid rises NUM_ACTIONS cycles later with action_data=0.
REQ-031 Reward 100 for action 0 -> Q[0]=25; next action=0.
REQ-032 Then reward -400 for action 0 -> Q[0]=-82; next action=1 (lowest-index tie among zeros).
REQ-033 action_ready held low for 5 cycles in ACTION -> action_valid stays 1 and action_data stays stable; reward_ready stays 0.
REQ-034 reward_valid raised before REWARD -> not accepted until reward_ready=1; exactly one table update occurs.
REQ-035 With EPSILON=255 over 10 iterations of random rewards -> action_data follows lfsr[15:8], and each reward is written only to the issued arm.
